// File: rtl/cnt_arbiter.sv
// Two-requester arbiter for one shared upcnt; round-robin, or req0-wins-ties when CNT_ARB_FIXED_PRI_EN is defined.
// Moore FSM IDLE->CLEAR->RUN->DONE, done rises target+1 edges after CLEAR; owner dropping req aborts, others wait in IDLE.
module cnt_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             a_reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             busy,
    output logic             cnt_start,
    output logic             cnt_s_reset,
    input  logic [WIDTH-1:0] count
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             owner;
    logic             pick;
    logic             owner_req;
    logic             abort;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] target_m1;

`ifdef CNT_ARB_FIXED_PRI_EN
    assign pick = ~req0;
`else
    logic rr_ptr;
    assign pick = (req0 && req1) ? rr_ptr : req1;
`endif

    assign owner_req = owner ? req1 : req0;
    assign abort     = ((state == ST_CLEAR) || (state == ST_RUN)) && !owner_req;
    assign target_m1 = target - WIDTH'(1);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (req0 || req1) state_nxt = ST_CLEAR;
            ST_CLEAR: begin
                if (abort)               state_nxt = ST_IDLE;
                else if (target == '0)   state_nxt = ST_DONE;
                else                     state_nxt = ST_RUN;
            end
            // count reaches target on the same edge that leaves RUN
            ST_RUN: begin
                if (abort)                    state_nxt = ST_IDLE;
                else if (count == target_m1)  state_nxt = ST_DONE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge a_reset) begin
        if (!a_reset) begin
            state  <= ST_IDLE;
            owner  <= 1'b0;
            target <= '0;
        end else begin
            state <= state_nxt;
            if ((state == ST_IDLE) && (req0 || req1)) begin
                owner  <= pick;
                target <= pick ? len1 : len0;
            end
        end
    end

`ifndef CNT_ARB_FIXED_PRI_EN
    // Both completion and abort hand the tie-break to the other requester.
    always_ff @(posedge clk or negedge a_reset) begin
        if (!a_reset) begin
            rr_ptr <= 1'b0;
        end else if ((state == ST_DONE) || abort) begin
            rr_ptr <= ~owner;
        end
    end
`endif

    assign busy        = (state != ST_IDLE);
    assign gnt0        = busy && !owner;
    assign gnt1        = busy && owner;
    assign done0       = (state == ST_DONE) && !owner;
    assign done1       = (state == ST_DONE) && owner;
    assign cnt_start   = (state == ST_RUN);
    assign cnt_s_reset = (state != ST_CLEAR);

endmodule
